// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
`timescale 1ns/1ps

package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int BITPOS_W   = $clog2(DATA_BITS);

  localparam logic [SAMPLE_W-1:0] MID_START   = SAMPLE_W'(7);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BITPOS_W-1:0] LAST_BIT    = BITPOS_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous active-low reset.
`timescale 1ns/1ps

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, driven by a 16x oversample tick.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
(
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  logic rxs;

  rx_state_e             state_q, state_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [BITPOS_W-1:0]   bitpos_q, bitpos_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  rdy_q, rdy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  line_wait_q, line_wait_d;
  logic                  parity_ok;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;
  assign parity_ok = ((^shift_q) == parity_bit_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bitpos_d    = bitpos_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    line_wait_d = line_wait_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif

    if (rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
    // After a break, a new start is only accepted once the line has gone high
    if (rxs) line_wait_d = 1'b0;

    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs && !line_wait_q) begin
            state_d  = START;
            sample_d = '0;
          end
        end
        START: begin
          if (rxs) begin
            state_d = IDLE;
          end else if (sample_q == MID_START) begin
            sample_d = '0;
            bitpos_d = '0;
            state_d  = DATA;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        DATA: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LAST_SAMPLE) begin
            shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
            bitpos_d = bitpos_q + 1'b1;
            if (bitpos_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LAST_SAMPLE) begin
            parity_bit_d = rxs;
            state_d      = STOP;
          end
        end
`endif
        STOP: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LAST_SAMPLE) begin
            state_d = IDLE;
            if (rxs && parity_ok) begin
              // A completion overrides a coincident rdy_clr
              data_d = shift_q;
              rdy_d  = 1'b1;
              if (rdy_q && !rdy_clr) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              if (!rxs) line_wait_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      bitpos_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      line_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      bitpos_q    <= bitpos_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      line_wait_q <= line_wait_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_50m) begin
    if (!rst_n) parity_bit_q <= 1'b0;
    else        parity_bit_q <= parity_bit_d;
  end
`endif

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor pops and compares.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_CYC  = 16 * TICK_DIV;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       clken;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       is_fe;
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic       prev_rdy  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #10 clk_50m = ~clk_50m;

  uart_rx dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .clken     (clken),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clken = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk_50m);
      #1 clken = 1'b1;
      @(posedge clk_50m);
      #1 clken = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk_50m) begin
    if (rst_n === 1'b1) begin
      if (frame_err === 1'b1 ||
          (rdy === 1'b1 && (prev_rdy !== 1'b1 || data !== prev_data))) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: actual frame_err=%b rdy=%b data=%0h required no event",
                   frame_err, rdy, data);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind_fe", 32'(frame_err), 32'(mon_e.is_fe));
          if (!mon_e.is_fe) begin
            check("rx_data", 32'(data), 32'(mon_e.data));
            check("overrun_at_byte", 32'(overrun), 32'(mon_e.ovr));
          end
        end
      end
    end
    prev_rdy  = rdy;
    prev_data = data;
  end

  task automatic expect_byte(input logic [7:0] d, input logic ovr);
    exp_t e;
    e.is_fe = 1'b0;
    e.data  = d;
    e.ovr   = ovr;
    exp_q.push_back(e);
  endtask

  task automatic expect_fe();
    exp_t e;
    e.is_fe = 1'b1;
    e.data  = 8'h00;
    e.ovr   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cyc(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d));
    send_bit(1'b1);
  endtask
`endif

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    wait_cyc(1);
    rdy_clr = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    wait_cyc(5);
    check("reset_data", 32'(data), 32'h00);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(BIT_CYC);

    // single good byte
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    idle(32);
    check("t1_rdy", 32'(rdy), 32'h1);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    pulse_clr();
    check("t1_rdy_cleared", 32'(rdy), 32'h0);

    // back-to-back without clearing: second completion overruns
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(32);
    check("t2_data", 32'(data), 32'hFF);
    check("t2_overrun", 32'(overrun), 32'h1);
    pulse_clr();
    check("t2_overrun_cleared", 32'(overrun), 32'h0);
    check("t2_rdy_cleared", 32'(rdy), 32'h0);

    // short low glitch is rejected
    rx = 1'b0;
    wait_cyc(4 * TICK_DIV);
    idle(2 * BIT_CYC);
    check("t3_rdy", 32'(rdy), 32'h0);
    check("t3_no_events_pending", 32'(exp_q.size()), 32'h0);

    // stop bit low: framing error, data retained
    expect_fe();
    send_frame(8'h3C, 1'b0);
    idle(BIT_CYC);
    check("t4_rdy", 32'(rdy), 32'h0);
    check("t4_data_kept", 32'(data), 32'hFF);

`ifdef UART_RX_PARITY_EN
    expect_byte(8'h07, 1'b0);
    send_frame(8'h07, 1'b1);
    idle(32);
    check("t6_good_parity_rdy", 32'(rdy), 32'h1);
    pulse_clr();
    expect_fe();
    send_frame_badpar(8'h07);
    idle(32);
    check("t6_bad_parity_rdy", 32'(rdy), 32'h0);
    check("t6_bad_parity_data", 32'(data), 32'h07);
`endif

    // reset mid-frame during bit 4 of 0x81
    v = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    rx = v[4];
    wait_cyc(BIT_CYC / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_cyc(3);
    check("t5_reset_data", 32'(data), 32'h00);
    check("t5_reset_rdy", 32'(rdy), 32'h0);
    check("t5_reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(2 * BIT_CYC);
    expect_byte(8'h42, 1'b0);
    send_frame(8'h42, 1'b1);
    idle(32);
    check("t5_data", 32'(data), 32'h42);
    check("t5_rdy", 32'(rdy), 32'h1);

    idle(2 * BIT_CYC);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
